// File: rtl/btn_debounce.sv
// Two-flop synchronizer and debounce FSM for each push-button. One channel
// instance per button; all channels run on clk156.
module btn_debounce_ch #(
    parameter int CNT_W           = 21,
    parameter int DEBOUNCE_CYCLES = 1562500
) (
    input  logic clk156,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] PRESS_WAIT   = 2'd1;
    localparam logic [1:0] PRESSED      = 2'd2;
    localparam logic [1:0] RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    // The FSM only ever looks at sync_q, never the raw pin.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk156) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_i;
            sync_q    <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
endmodule

module btn_debounce #(
    parameter int NUM_BTN         = 5,
    parameter int CNT_W           = 21,
    parameter int DEBOUNCE_CYCLES = 1562500
) (
    input  logic               clk156,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release
);
    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        btn_debounce_ch #(
            .CNT_W          (CNT_W),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk156   (clk156),
            .rst      (rst),
            .btn_i    (btn_in[i]),
            .level_o  (btn_level[i]),
            .press_o  (btn_press[i]),
            .release_o(btn_release[i])
        );
    end
endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: a run-length reference model feeds an expected-output
// queue that a negedge monitor drains and compares against the DUT.
module tb_btn_debounce;
    localparam int NB = 5;
    localparam int D  = 4;

    typedef struct packed {
        logic [NB-1:0] lvl;
        logic [NB-1:0] prs;
        logic [NB-1:0] rel;
    } exp_t;

    logic          clk156 = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_level, btn_press, btn_release;

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    btn_debounce #(.NUM_BTN(NB), .CNT_W(3), .DEBOUNCE_CYCLES(D)) dut (
        .clk156     (clk156),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk156 = ~clk156;

    // Reference: a new level is accepted once the synchronized input has
    // disagreed with the current level for D+1 consecutive samples.
    initial begin
        bit m_s1[NB];
        bit m_s[NB];
        bit m_lvl[NB];
        int m_run[NB];
        exp_t e;
        for (int i = 0; i < NB; i++) begin
            m_s1[i] = 0; m_s[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
        end
        forever begin
            @(posedge clk156);
            e = '0;
            for (int i = 0; i < NB; i++) begin
                if (rst) begin
                    m_s1[i] = 0; m_s[i] = 0; m_lvl[i] = 0; m_run[i] = 0;
                end else begin
                    if (m_s[i] != m_lvl[i]) begin
                        m_run[i]++;
                        if (m_run[i] == D + 1) begin
                            m_lvl[i] = m_s[i];
                            if (m_s[i]) e.prs[i] = 1'b1;
                            else        e.rel[i] = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                    m_s[i]  = m_s1[i];
                    m_s1[i] = btn_in[i];
                end
                e.lvl[i] = m_lvl[i];
            end
            exp_q.push_back(e);
        end
    end

    task automatic cmp(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle, so one expectation per edge.
    initial begin
        exp_t e;
        @(posedge clk156);
        forever begin
            @(negedge clk156);
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL scoreboard_empty at %0t: got 0 entries expected >=1", $time);
            end else begin
                e = exp_q.pop_front();
                cmp("btn_level", btn_level, e.lvl);
                cmp("btn_press", btn_press, e.prs);
                cmp("btn_release", btn_release, e.rel);
                cmp("press_and_release", btn_press & btn_release, '0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk156);
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 5'b11111;
        cyc(3);
        cmp("reset_level", btn_level, 5'b00000);
        rst    = 1'b0;
        btn_in = 5'b00000;
        cyc(10);
        cmp("idle_level", btn_level, 5'b00000);

        // Clean press on bit 1: visible exactly after E0+6
        btn_in[1] = 1'b1;
        cyc(6);
        cmp("press1_early", btn_level, 5'b00000);
        cyc(1);
        cmp("press1_level", btn_level, 5'b00010);
        cyc(5);

        // Bounce on bit 2 with 3-cycle periods is rejected
        btn_in[2] = 1'b1; cyc(3);
        btn_in[2] = 1'b0; cyc(3);
        btn_in[2] = 1'b1; cyc(3);
        btn_in[2] = 1'b0; cyc(10);
        cmp("bounce_level", btn_level, 5'b00010);

        // Press then release bit 0
        btn_in[0] = 1'b1; cyc(10);
        cmp("press0_level", btn_level, 5'b00011);
        btn_in[0] = 1'b0; cyc(6);
        cmp("release0_early", btn_level, 5'b00011);
        cyc(1);
        cmp("release0_level", btn_level, 5'b00010);
        cyc(5);
        btn_in[1] = 1'b0; cyc(10);
        cmp("release1_level", btn_level, 5'b00000);

        // Simultaneous press on bits 4:3
        btn_in[4:3] = 2'b11; cyc(10);
        cmp("simul_level", btn_level, 5'b11000);
        btn_in = 5'b00000; cyc(10);
        cmp("all_released", btn_level, 5'b00000);

        // Reset while bit 1 sits at cnt=3 in PRESS_WAIT
        btn_in[1] = 1'b1;
        cyc(5);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(6);
        cmp("midwin_early", btn_level, 5'b00000);
        cyc(1);
        cmp("midwin_level", btn_level, 5'b00010);
        cyc(3);

        // Random toggling with occasional resets
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < NB; b++)
                if ($urandom_range(0, 4) == 0) btn_in[b] = ~btn_in[b];
            rst = ($urandom_range(0, 99) == 0);
            cyc(1);
        end
        rst = 1'b0;
        cyc(15);
        cmp("final_level", btn_level, btn_in);

        @(posedge clk156);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
